servo_scan: RTL and testbench
=============================

SERVO_SCAN -- requirements
Module: servo_scan

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 25_000_000, clk cycles the servo is given to reach each commanded position.
REQ-002 SHALL have parameter MEAS_TIMEOUT, default 5_000_000, maximum clk cycles waited for meas_ack per measurement.
REQ-003 SHALL have parameter DW, default 16, width of measurement data.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  scan request; sampled only in IDLE.
REQ-007 abort  input  1  cancels a running scan.
REQ-008 meas_ack  input  1  distance sensor reports meas_data valid.
REQ-009 meas_data  input  DW  distance value from sensor.
REQ-010 posicion  output  2  servo position command to the PWM stage: 00 centre, 01 left, 10 right; 11 never driven.
REQ-011 meas_req  output  1  request one distance measurement.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on scan completion.
REQ-014 dist_left, dist_center, dist_right  output  DW each  last captured distances.

Function
REQ-015 States SHALL be IDLE, MOVE_L, MEAS_L, MOVE_C, MEAS_C, MOVE_R, MEAS_R, RETURN, DONE.
REQ-016 posicion SHALL be 01 in MOVE_L/MEAS_L, 00 in MOVE_C/MEAS_C, 10 in MOVE_R/MEAS_R, 00 in IDLE/RETURN/DONE.
REQ-017 IDLE with start=1 and abort=0 SHALL enter MOVE_L next cycle; start while busy=1 SHALL be ignored.
REQ-018 Each MOVE_x and RETURN SHALL last exactly SETTLE_CYCLES cycles (counter cleared on entry, exit when count reaches SETTLE_CYCLES-1).
REQ-019 MOVE_L->MEAS_L, MOVE_C->MEAS_C, MOVE_R->MEAS_R; MEAS_L->MOVE_C, MEAS_C->MOVE_R, MEAS_R->RETURN; RETURN->DONE; DONE->IDLE after one cycle.
REQ-020 meas_req SHALL be high in every cycle spent in a MEAS_x state and low elsewhere.
REQ-021 In MEAS_x, the cycle meas_ack=1 SHALL register meas_data into the matching dist_x and leave the state next cycle; meas_ack outside MEAS_x SHALL be ignored.
REQ-022 done SHALL be high exactly during the single DONE cycle; busy SHALL be low in that cycle's successor.
REQ-023 abort=1 in any state other than IDLE SHALL force RETURN next cycle (settle counter restarted), then IDLE without passing through DONE; no dist_x captured that cycle.
REQ-024 abort=1 during RETURN SHALL restart nothing; RETURN completes normally but SHALL then go to IDLE, not DONE.
REQ-025 start and abort both high in IDLE: abort wins, state stays IDLE.
REQ-026 dist_x registers SHALL hold their value across scans until overwritten by a capture.
REQ-027 Counter width SHALL be clog2 of max(SETTLE_CYCLES, MEAS_TIMEOUT) with no wrap before terminal count.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, posicion=00, meas_req=0, busy=0, done=0, counter=0, all dist_x=0, including mid-scan.

Configuration
REQ-029 Macro SERVO_SCAN_TIMEOUT_EN defined: a MEAS_x state with no meas_ack for MEAS_TIMEOUT cycles SHALL load all-ones into dist_x and advance as if acked; meas_ack in the terminal cycle wins and captures meas_data.
REQ-030 Macro SERVO_SCAN_TIMEOUT_EN undefined: MEAS_x SHALL wait indefinitely for meas_ack or abort; MEAS_TIMEOUT unused.

Verification (SETTLE_CYCLES=4, MEAS_TIMEOUT=8, DW=16)
REQ-031 Reset then start pulse, meas_ack one cycle after each meas_req rise with data 100/200/300 -> posicion 01,00,10,00 each held 4 cycles plus MEAS, dist_left=100, dist_center=200, dist_right=300, single done pulse, busy low after.
REQ-032 start held high for whole scan -> exactly one scan, second start only accepted after returning to IDLE.
REQ-033 abort during MEAS_C -> meas_req drops next cycle, posicion=00 for 4 cycles, IDLE, no done, dist_center unchanged, dist_left updated.
REQ-034 With SERVO_SCAN_TIMEOUT_EN, no meas_ack at MEAS_R -> after 8 cycles dist_right=16'hFFFF, scan completes with done; without macro -> stays in MEAS_R, meas_req high, until ack.
REQ-035 rst_n low during MOVE_R -> next cycle all outputs at reset values, dist_x=0.
REQ-036 start and abort together in IDLE -> busy stays 0, posicion 00.

Source files
------------

// File: rtl/servo_scan.sv
// servo_scan: left/centre/right servo sweep with one distance capture per point.
// Define SERVO_SCAN_TIMEOUT_EN to bound each measurement wait by MEAS_TIMEOUT.
module servo_scan #(
  parameter int SETTLE_CYCLES = 25_000_000,
  parameter int MEAS_TIMEOUT  = 5_000_000,
  parameter int DW            = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          meas_ack,
  input  logic [DW-1:0] meas_data,
  output logic [1:0]    posicion,
  output logic          meas_req,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dist_left,
  output logic [DW-1:0] dist_center,
  output logic [DW-1:0] dist_right
);

  localparam int MAXC = (SETTLE_CYCLES > MEAS_TIMEOUT) ?
                        SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SET_END = CW'(SETTLE_CYCLES - 1);
`ifdef SERVO_SCAN_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_END = CW'(MEAS_TIMEOUT - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, MOVE_L, MEAS_L, MOVE_C, MEAS_C,
    MOVE_R, MEAS_R, RETURN, DONE
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          ab;
  logic          settled;
  logic          in_meas;
  logic          tmo;
  logic          adv;
  logic          cnt_run;

  always_comb begin
    nxt     = state;
    settled = (cnt == SET_END);
    in_meas = (state == MEAS_L) || (state == MEAS_C) ||
              (state == MEAS_R);
`ifdef SERVO_SCAN_TIMEOUT_EN
    tmo     = in_meas && !meas_ack && (cnt == TMO_END);
    cnt_run = (state != IDLE);
`else
    tmo     = 1'b0;
    cnt_run = (state != IDLE) && !in_meas;
`endif
    adv = in_meas && (meas_ack || tmo) && !abort;
    unique case (state)
      IDLE:    if (start && !abort) nxt = MOVE_L;
      MOVE_L:  if (settled) nxt = MEAS_L;
      MEAS_L:  if (adv) nxt = MOVE_C;
      MOVE_C:  if (settled) nxt = MEAS_C;
      MEAS_C:  if (adv) nxt = MOVE_R;
      MOVE_R:  if (settled) nxt = MEAS_R;
      MEAS_R:  if (adv) nxt = RETURN;
      RETURN:  if (settled) nxt = (ab || abort) ? IDLE : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // RETURN ignores abort apart from skipping DONE at its end
    if (abort && state != IDLE && state != RETURN) nxt = RETURN;
  end

  always_comb begin
    posicion = 2'b00;
    unique case (1'b1)
      (state == MOVE_L) || (state == MEAS_L): posicion = 2'b01;
      (state == MOVE_R) || (state == MEAS_R): posicion = 2'b10;
      default:                                posicion = 2'b00;
    endcase
    meas_req = in_meas;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ab          <= 1'b0;
      dist_left   <= '0;
      dist_center <= '0;
      dist_right  <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1'b1;
      if (state == IDLE) ab <= 1'b0;
      else if (abort) ab <= 1'b1;
      if (adv && state == MEAS_L)
        dist_left <= tmo ? '1 : meas_data;
      if (adv && state == MEAS_C)
        dist_center <= tmo ? '1 : meas_data;
      if (adv && state == MEAS_R)
        dist_right <= tmo ? '1 : meas_data;
    end
  end

endmodule

// File: tb/tb_servo_scan.sv
// tb_servo_scan: randomized scans against a per-cycle expected trace.
// Honours SERVO_SCAN_TIMEOUT_EN for the measurement-timeout scenario.
module tb_servo_scan;

  localparam int S = 4;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        meas_ack = 1'b0;
  logic [15:0] meas_data = '0;
  logic [1:0]  posicion;
  logic        meas_req, busy, done;
  logic [15:0] dist_left, dist_center, dist_right;

  servo_scan #(.SETTLE_CYCLES(S), .MEAS_TIMEOUT(T), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .meas_ack(meas_ack), .meas_data(meas_data),
    .posicion(posicion), .meas_req(meas_req), .busy(busy),
    .done(done), .dist_left(dist_left),
    .dist_center(dist_center), .dist_right(dist_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pos;
    logic        req;
    logic        busy;
    logic        done;
    logic        ack;
    logic        abt;
    logic        st;
    logic [15:0] data;
  } cyc_t;

  cyc_t        q[$];
  logic [4:0]  obs[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_l = '0, exp_c = '0, exp_r = '0;

  task automatic clr();
    q.delete();
    obs.delete();
  endtask

  task automatic push(input logic [1:0] p, input logic r, b, d,
                      input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.pos = p; c.req = r; c.busy = b; c.done = d;
      c.ack = 1'b0; c.abt = 1'b0; c.st = 1'b0; c.data = '0;
      q.push_back(c);
    end
  endtask

  // k == 0 means never acked: the timeout fills all-ones after T cycles
  task automatic meas_ph(input logic [1:0] p, input int k,
                         input logic [15:0] d,
                         output logic [15:0] cap);
    if (k == 0) begin
      push(p, 1'b1, 1'b1, 1'b0, T);
      cap = 16'hFFFF;
    end else begin
      push(p, 1'b1, 1'b1, 1'b0, k);
      q[q.size()-1].ack = 1'b1;
      q[q.size()-1].data = d;
      cap = d;
    end
  endtask

  task automatic build_scan(input int kl, kc, kr,
                            input logic [15:0] dl, dc, dr);
    push(2'b01, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b01, kl, dl, exp_l);
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b00, kc, dc, exp_c);
    push(2'b10, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b10, kr, dr, exp_r);
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    push(2'b00, 1'b0, 1'b1, 1'b1, 1);
    push(2'b00, 1'b0, 1'b0, 1'b0, 1);
  endtask

  // Drives the trace's inputs cycle by cycle and records the outputs;
  // acks outside a measurement are random noise the DUT must ignore.
  task automatic play(input logic st0, ab0);
    start = st0;
    abort = ab0;
    meas_ack = 1'b0;
    foreach (q[i]) begin
      @(posedge clk); #1;
      obs.push_back({posicion, meas_req, busy, done});
      start = q[i].st;
      abort = q[i].abt;
      if (q[i].req) begin
        meas_ack = q[i].ack;
        meas_data = q[i].ack ? q[i].data : 16'($urandom);
      end else begin
        meas_ack = 1'($urandom);
        meas_data = 16'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    meas_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      meas_ack = 1'($urandom);
      meas_data = 16'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({posicion, meas_req, busy, done, dist_left,
           dist_center, dist_right} !== 53'd0) begin
        fails++;
        $display("FAIL reset cyc %0d: pos=%b req=%b busy=%b done=%b dl=%0d dc=%0d dr=%0d, expected all zero",
                 i, posicion, meas_req, busy, done,
                 dist_left, dist_center, dist_right);
      end
    end
    start = 1'b0;
    meas_ack = 1'b0;
    rst_n = 1'b1;
    exp_l = '0; exp_c = '0; exp_r = '0;
  endtask

  task automatic test_scan();
    clr();
    build_scan(2, 2, 2, 16'd100, 16'd200, 16'd300);
    play(1'b1, 1'b0);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL scan cyc %0d: pos_req_busy_done=%b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
    tests++;
    if ({dist_left, dist_center, dist_right} !== {exp_l, exp_c, exp_r}) begin
      fails++;
      $display("FAIL scan dist: %0d %0d %0d, expected %0d %0d %0d",
               dist_left, dist_center, dist_right, exp_l, exp_c, exp_r);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      clr();
      build_scan($urandom_range(1, 6), $urandom_range(1, 6),
                 $urandom_range(1, 6), 16'($urandom),
                 16'($urandom), 16'($urandom));
      play(1'b1, 1'b0);
      foreach (q[i]) begin
        tests++;
        if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
          fails++;
          $display("FAIL random scan %0d cyc %0d: got %b, expected %b",
                   n, i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
        end
      end
      tests++;
      if ({dist_left, dist_center, dist_right} !== {exp_l, exp_c, exp_r}) begin
        fails++;
        $display("FAIL random dist %0d: %h %h %h, expected %h %h %h", n,
                 dist_left, dist_center, dist_right, exp_l, exp_c, exp_r);
      end
    end
  endtask

  task automatic test_start_held();
    clr();
    build_scan(1, 2, 3, 16'd11, 16'd22, 16'd33);
    foreach (q[i]) q[i].st = 1'b1;
    push(2'b01, 1'b0, 1'b1, 1'b0, 1);
    q[q.size()-1].abt = 1'b1;
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    push(2'b00, 1'b0, 1'b0, 1'b0, 1);
    play(1'b1, 1'b0);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL start_held cyc %0d: got %b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
  endtask

  task automatic test_abort_meas_c();
    int m;
    logic [15:0] old_c;
    clr();
    old_c = exp_c;
    m = $urandom_range(1, 4);
    push(2'b01, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b01, $urandom_range(1, 4), 16'($urandom), exp_l);
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    push(2'b00, 1'b1, 1'b1, 1'b0, m);
    q[q.size()-1].abt = 1'b1;
    q[q.size()-1].ack = 1'b1;
    q[q.size()-1].data = ~old_c;
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    push(2'b00, 1'b0, 1'b0, 1'b0, 2);
    play(1'b1, 1'b0);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL abort_meas_c cyc %0d: got %b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
    tests++;
    if ({dist_left, dist_center, dist_right} !== {exp_l, old_c, exp_r}) begin
      fails++;
      $display("FAIL abort_meas_c dist: %h %h %h, expected %h %h %h",
               dist_left, dist_center, dist_right, exp_l, old_c, exp_r);
    end
  endtask

  task automatic test_abort_return();
    clr();
    build_scan(1, 1, 1, 16'($urandom), 16'($urandom), 16'($urandom));
    q[q.size()-5].abt = 1'b1;
    q[q.size()-2].busy = 1'b0;
    q[q.size()-2].done = 1'b0;
    play(1'b1, 1'b0);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL abort_return cyc %0d: got %b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
    tests++;
    if ({dist_left, dist_center, dist_right} !== {exp_l, exp_c, exp_r}) begin
      fails++;
      $display("FAIL abort_return dist: %h %h %h, expected %h %h %h",
               dist_left, dist_center, dist_right, exp_l, exp_c, exp_r);
    end
  endtask

  task automatic test_timeout();
    for (int n = 0; n < 2; n++) begin
      clr();
      if (n == 0) begin
`ifdef SERVO_SCAN_TIMEOUT_EN
        build_scan(1, 3, 0, 16'd5, 16'd6, 16'd7);
`else
        build_scan(1, 3, 20, 16'd5, 16'd6, 16'd7);
`endif
      end else begin
        build_scan(T, 1, T, 16'h1234, 16'h5678, 16'h9ABC);
      end
      play(1'b1, 1'b0);
      foreach (q[i]) begin
        tests++;
        if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
          fails++;
          $display("FAIL timeout %0d cyc %0d: got %b, expected %b",
                   n, i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
        end
      end
      tests++;
      if ({dist_left, dist_center, dist_right} !== {exp_l, exp_c, exp_r}) begin
        fails++;
        $display("FAIL timeout %0d dist: %h %h %h, expected %h %h %h", n,
                 dist_left, dist_center, dist_right, exp_l, exp_c, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    clr();
    push(2'b01, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b01, $urandom_range(1, 4), 16'($urandom), exp_l);
    push(2'b00, 1'b0, 1'b1, 1'b0, S);
    meas_ph(2'b00, $urandom_range(1, 4), 16'($urandom), exp_c);
    push(2'b10, 1'b0, 1'b1, 1'b0, 2);
    play(1'b1, 1'b0);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got %b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    exp_l = '0; exp_c = '0; exp_r = '0;
    tests++;
    if ({posicion, meas_req, busy, done, dist_left,
         dist_center, dist_right} !== 53'd0) begin
      fails++;
      $display("FAIL reset_mid: pos=%b req=%b busy=%b done=%b dl=%0d dc=%0d dr=%0d, expected all zero",
               posicion, meas_req, busy, done,
               dist_left, dist_center, dist_right);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_start_abort_idle();
    clr();
    push(2'b00, 1'b0, 1'b0, 1'b0, 4);
    foreach (q[i]) begin
      q[i].st = 1'b1;
      q[i].abt = 1'b1;
    end
    play(1'b1, 1'b1);
    foreach (q[i]) begin
      tests++;
      if (obs[i] !== {q[i].pos, q[i].req, q[i].busy, q[i].done}) begin
        fails++;
        $display("FAIL start_abort_idle cyc %0d: got %b, expected %b",
                 i, obs[i], {q[i].pos, q[i].req, q[i].busy, q[i].done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_random();
    test_start_held();
    test_abort_meas_c();
    test_abort_return();
    test_timeout();
    test_reset_mid();
    test_start_abort_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
